shift_seq_ctrl: RTL
===================

Name: shift_seq_ctrl

Overview:
- Multi-cycle controller that executes one 8-bit shift/rotate command over a valid/ready command interface.
- Applies one single-bit step per clock until the shift count is exhausted.
- Presents the result on a valid/ready result interface, with overflow and illegal-op flags.
- Sits between the switch/command front end and the display/result logic; serial replacement for the combinational shift unit, using the same 3-bit op encoding.

Parameters:
- WIDTH, 8, data width in bits (at least 2).
- CNT_W, 3, shift-count width; counts range 0 to 2^CNT_W-1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  controller can accept a command.
- cmd_op  input  3  000 none, 001 logical left, 010 arithmetic left, 011 logical right, 100 arithmetic right, 101 rotate left, 110 rotate right, 111 reserved.
- cmd_data  input  WIDTH  signed operand.
- cmd_count  input  CNT_W  number of bit positions.
- res_valid  output  1  result valid.
- res_ready  input  1  consumer accepts result.
- res_data  output  WIDTH  shifted result.
- res_ovf  output  1  arithmetic-left sign change occurred.
- res_err  output  1  op 111 was issued.
- busy  output  1  high in SHIFT or DONE.
- steps_left  output  CNT_W  remaining steps; 0 outside SHIFT.

Behaviour:
- States: IDLE, SHIFT, DONE. Encoding is free; state is not externally visible except via busy/cmd_ready/res_valid.
- Reset (sync, rst=1 at edge) forces state to IDLE and clears all registers.
  - Reset values: cmd_ready=1, res_valid=0, res_data=0, res_ovf=0, res_err=0, busy=0, steps_left=0.
  - Reset overrides every other event, including mid-SHIFT or during DONE. Any in-flight command is discarded with no result.
- cmd_ready=1 only in IDLE. Acceptance occurs at an edge with cmd_valid & cmd_ready (edge E0). At E0 the controller latches data, op and count, and clears ovf.
- If count==0, or op is 000 or 111, the controller goes directly to DONE at E0 with res_data=cmd_data. res_err=1 if op==111.
- Otherwise it enters SHIFT at E0 with steps_left=count.
  - At each following edge in SHIFT it applies one 1-bit step and decrements steps_left.
  - On the edge where steps_left goes 1 to 0 it enters DONE.
  - res_valid is therefore first high in the cycle after edge E_count (latency = count clocks after acceptance; 0 extra for trivial ops).
- Single-bit step definitions (bit width W=WIDTH):
  - Logical left: shift left, LSB<=0.
  - Arithmetic left: same as logical left; set ovf sticky if new MSB != old MSB.
  - Logical right: MSB<=0.
  - Arithmetic right: MSB replicated.
  - Rotate left: LSB<=old MSB.
  - Rotate right: MSB<=old LSB.
  - Count saturation: none is needed; rotates by count>=W simply wrap naturally.
- DONE: res_valid=1. res_data/res_ovf/res_err are held stable until the handshake. At an edge with res_ready=1 the controller returns to IDLE and res_valid drops.
  - cmd_ready stays 0 in DONE. No same-cycle turnaround: a new command is accepted no earlier than the cycle after the result handshake.
- cmd_* inputs are ignored while not in IDLE. A changing cmd_data mid-operation must not affect the result.
- res_ready outside DONE has no effect.
- Back-pressure: DONE may be held indefinitely; outputs remain constant.
- busy = (state != IDLE).

Test Plan:
- Reset then idle: assert rst for 2 cycles mid-SHIFT of a count=5 command -> next cycle cmd_ready=1, res_valid=0, res_data=0, busy=0, and no result is ever produced.
- Rotate left: data=0x96, op=101, count=3, res_ready=1 -> res_valid first high 3 cycles after acceptance, res_data=0xB4; steps_left observed 3,2,1 during SHIFT.
- Arithmetic vs logical right: data=0x96, op=100, count=2 -> 0xE5; then op=011, count=2 -> 0x25; ovf=0, err=0 both times.
- Overflow flag: data=0x40, op=010, count=1 -> res_data=0x80, res_ovf=1; same with op=001 -> res_data=0x80, res_ovf=0. Also op=010 data=0x20 count=3 -> 0x00, ovf=1 (sticky from the step-2 sign change).
- Trivial ops: count=0 with op=101 data=0x5A -> res_data=0x5A one cycle after acceptance. op=111 count=4 data=0x33 -> res_data=0x33, res_err=1.
- Back-pressure: op=110 data=0x01 count=1, hold res_ready=0 for 10 cycles while toggling cmd_valid and cmd_data -> res_valid stays 1, res_data=0x80 stable, cmd_ready=0. Raise res_ready -> IDLE next cycle, and the held command is accepted one cycle later.

Source files
------------

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: serial shift/rotate engine. It accepts one command over a
// valid/ready interface, applies one single-bit step per clock, and holds the
// result on a valid/ready interface until the consumer takes it.
module shift_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_count,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_ovf,
  output logic             res_err,
  output logic             busy,
  output logic [CNT_W-1:0] steps_left
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  localparam logic [2:0] OP_NONE = 3'b000;
  localparam logic [2:0] OP_LSL  = 3'b001;
  localparam logic [2:0] OP_ASL  = 3'b010;
  localparam logic [2:0] OP_LSR  = 3'b011;
  localparam logic [2:0] OP_ASR  = 3'b100;
  localparam logic [2:0] OP_ROL  = 3'b101;
  localparam logic [2:0] OP_ROR  = 3'b110;
  localparam logic [2:0] OP_RSV  = 3'b111;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [2:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] step_data;
  logic             step_ovf;
  logic             trivial;

  // One single-bit step of the latched op applied to the working register
  always_comb begin
    step_data = data_q;
    step_ovf  = 1'b0;
    case (op_q)
      OP_LSL: step_data = {data_q[WIDTH-2:0], 1'b0};
      OP_ASL: begin
        step_data = {data_q[WIDTH-2:0], 1'b0};
        step_ovf  = data_q[WIDTH-1] ^ data_q[WIDTH-2];
      end
      OP_LSR: step_data = {1'b0, data_q[WIDTH-1:1]};
      OP_ASR: step_data = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
      OP_ROL: step_data = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
      OP_ROR: step_data = {data_q[0], data_q[WIDTH-1:1]};
      default: step_data = data_q;
    endcase
  end

  // Zero count, no-op and reserved op skip SHIFT and report the operand as-is
  assign trivial = (cmd_count == '0) || (cmd_op == OP_NONE) || (cmd_op == OP_RSV);

  // Next-state and datapath update; cmd_* only matter in IDLE
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          data_d = cmd_data;
          op_d   = cmd_op;
          ovf_d  = 1'b0;
          err_d  = (cmd_op == OP_RSV);
          if (trivial) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d   = cmd_count;
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        data_d = step_data;
        ovf_d  = ovf_q | step_ovf;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = DONE;
      end
      DONE: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; synchronous reset discards any command
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      op_q    <= OP_NONE;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  assign cmd_ready  = (state_q == IDLE);
  assign res_valid  = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign res_data   = data_q;
  assign res_ovf    = ovf_q;
  assign res_err    = err_q;
  assign steps_left = (state_q == SHIFT) ? cnt_q : '0;

endmodule
